// File: rtl/reg_acc_arbiter_if.sv
// reg_acc_arbiter_if: upstream requester and downstream register-access signals of the arbiter
interface reg_acc_arbiter_if #(
  parameter int MST_NUM    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [MST_NUM-1:0]            mst__arb__req_vld;
  logic [MST_NUM-1:0]            arb__mst__req_rdy;
  logic [MST_NUM*ADDR_WIDTH-1:0] mst__arb__addr;
  logic [MST_NUM-1:0]            mst__arb__wr_en;
  logic [MST_NUM-1:0]            mst__arb__rd_en;
  logic [MST_NUM*DATA_WIDTH-1:0] mst__arb__wr_data;
  logic [MST_NUM-1:0]            mst__arb__sync_reset;
  logic [MST_NUM-1:0]            arb__mst__ack_vld;
  logic [MST_NUM-1:0]            mst__arb__ack_rdy;
  logic [DATA_WIDTH-1:0]         arb__mst__rd_data;
  logic                          arb__slv__req_vld;
  logic [ADDR_WIDTH-1:0]         arb__slv__addr;
  logic                          arb__slv__wr_en;
  logic                          arb__slv__rd_en;
  logic [DATA_WIDTH-1:0]         arb__slv__wr_data;
  logic                          slv__arb__req_rdy;
  logic                          slv__arb__ack_vld;
  logic [DATA_WIDTH-1:0]         slv__arb__rd_data;
  logic                          arb__slv__ack_rdy;
  logic                          arb__slv__sync_reset;
  logic [MST_NUM-1:0]            arb__grant;
  // arbiter side
  modport slave (
    input  mst__arb__req_vld, mst__arb__addr, mst__arb__wr_en, mst__arb__rd_en, mst__arb__wr_data,
    input  mst__arb__sync_reset, mst__arb__ack_rdy, slv__arb__req_rdy, slv__arb__ack_vld, slv__arb__rd_data,
    output arb__mst__req_rdy, arb__mst__ack_vld, arb__mst__rd_data, arb__slv__req_vld, arb__slv__addr,
    output arb__slv__wr_en, arb__slv__rd_en, arb__slv__wr_data, arb__slv__ack_rdy, arb__slv__sync_reset,
    output arb__grant
  );
  // requesters plus downstream slave side
  modport master (
    output mst__arb__req_vld, mst__arb__addr, mst__arb__wr_en, mst__arb__rd_en, mst__arb__wr_data,
    output mst__arb__sync_reset, mst__arb__ack_rdy, slv__arb__req_rdy, slv__arb__ack_vld, slv__arb__rd_data,
    input  arb__mst__req_rdy, arb__mst__ack_vld, arb__mst__rd_data, arb__slv__req_vld, arb__slv__addr,
    input  arb__slv__wr_en, arb__slv__rd_en, arb__slv__wr_data, arb__slv__ack_rdy, arb__slv__sync_reset,
    input  arb__grant
  );
endinterface

// File: rtl/reg_acc_arbiter.sv
// reg_acc_arbiter: round-robin arbiter sharing one register-access port, one transaction in flight
module reg_acc_arbiter #(
  parameter int MST_NUM    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rstn,
  reg_acc_arbiter_if.slave  bus
);
  localparam int IW = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2;
  logic [1:0]    state;
  logic [IW-1:0] ptr, gidx, win, nxt;
  logic [IW:0]   s;
  logic          any, hs, abort;
  // first requester at or above ptr wins, wrapping; scanning downward lets the nearest overwrite
  always_comb begin
    win = '0;
    any = 1'b0;
    s   = '0;
    for (int k = MST_NUM - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      s = (s >= (IW+1)'(MST_NUM)) ? s - (IW+1)'(MST_NUM) : s;
      if (bus.mst__arb__req_vld[s[IW-1:0]]) begin
        win = s[IW-1:0];
        any = 1'b1;
      end
    end
  end
  assign hs    = (state == ACK) && bus.slv__arb__ack_vld && bus.mst__arb__ack_rdy[gidx];
  assign abort = (state != IDLE) && bus.mst__arb__sync_reset[gidx];
  assign nxt   = (gidx == IW'(MST_NUM - 1)) ? '0 : gidx + 1'b1;
  assign bus.arb__mst__req_rdy = (state == REQ) ? bus.arb__grant & {MST_NUM{bus.slv__arb__req_rdy}} : '0;
  assign bus.arb__mst__ack_vld = (state == ACK) ? bus.arb__grant & {MST_NUM{bus.slv__arb__ack_vld}} : '0;
  assign bus.arb__slv__ack_rdy = (state == ACK) && bus.mst__arb__ack_rdy[gidx];
  assign bus.arb__mst__rd_data = (state == ACK) ? bus.slv__arb__rd_data : '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                    <= IDLE;
      ptr                      <= '0;
      gidx                     <= '0;
      bus.arb__grant           <= '0;
      bus.arb__slv__req_vld    <= 1'b0;
      bus.arb__slv__addr       <= '0;
      bus.arb__slv__wr_en      <= 1'b0;
      bus.arb__slv__rd_en      <= 1'b0;
      bus.arb__slv__wr_data    <= '0;
      bus.arb__slv__sync_reset <= 1'b0;
    end else begin
      bus.arb__slv__sync_reset <= 1'b0;
      if (state == IDLE && any) begin
        state                 <= REQ;
        gidx                  <= win;
        bus.arb__grant        <= MST_NUM'(1) << win;
        bus.arb__slv__req_vld <= 1'b1;
        bus.arb__slv__addr    <= bus.mst__arb__addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        bus.arb__slv__wr_en   <= bus.mst__arb__wr_en[win];
        bus.arb__slv__rd_en   <= bus.mst__arb__rd_en[win];
        bus.arb__slv__wr_data <= bus.mst__arb__wr_data[win*DATA_WIDTH +: DATA_WIDTH];
      end else if (hs || abort) begin
        // a completing handshake takes priority over a simultaneous abort
        state                    <= IDLE;
        ptr                      <= nxt;
        bus.arb__grant           <= '0;
        bus.arb__slv__req_vld    <= 1'b0;
        bus.arb__slv__wr_en      <= 1'b0;
        bus.arb__slv__rd_en      <= 1'b0;
        bus.arb__slv__sync_reset <= !hs;
      end else if (state == REQ && bus.slv__arb__req_rdy) begin
        state                 <= ACK;
        bus.arb__slv__req_vld <= 1'b0;
        bus.arb__slv__wr_en   <= 1'b0;
        bus.arb__slv__rd_en   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reg_acc_arbiter.sv
// tb_reg_acc_arbiter: directed and randomized checks of the round-robin register-access arbiter
module tb_reg_acc_arbiter;
  localparam int N = 4, AW = 64, DW = 32;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  reg_acc_arbiter_if #(.MST_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  reg_acc_arbiter #(.MST_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int total = 0;
  int bad = 0;
  int mptr = 0;
  logic [AW-1:0] addr_q [N];
  logic [DW-1:0] data_q [N];

  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.mst__arb__req_vld = '0;
    bus.mst__arb__addr = '0;
    bus.mst__arb__wr_en = '0;
    bus.mst__arb__rd_en = '0;
    bus.mst__arb__wr_data = '0;
    bus.mst__arb__sync_reset = '0;
    bus.mst__arb__ack_rdy = '0;
    bus.slv__arb__req_rdy = 1'b0;
    bus.slv__arb__ack_vld = 1'b0;
    bus.slv__arb__rd_data = '0;
  endtask

  task automatic load(input int i, input logic w, input logic r);
    addr_q[i] = {$urandom, $urandom};
    data_q[i] = $urandom;
    bus.mst__arb__addr[i*AW +: AW] = addr_q[i];
    bus.mst__arb__wr_data[i*DW +: DW] = data_q[i];
    bus.mst__arb__wr_en[i] = w;
    bus.mst__arb__rd_en[i] = r;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    mptr = 0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle_inputs();
    bus.mst__arb__req_vld = '1;
    bus.mst__arb__ack_rdy = '1;
    bus.slv__arb__req_rdy = 1'b1;
    bus.slv__arb__ack_vld = 1'b1;
    bus.slv__arb__rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (bus.arb__grant !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", bus.arb__grant); end
    total++; if ({bus.arb__slv__req_vld, bus.arb__slv__wr_en, bus.arb__slv__rd_en, bus.arb__slv__sync_reset, bus.arb__slv__ack_rdy} !== 5'b0) begin
      bad++; $display("FAIL rst_slv_ctrl got=%b exp=0", {bus.arb__slv__req_vld, bus.arb__slv__wr_en, bus.arb__slv__rd_en, bus.arb__slv__sync_reset, bus.arb__slv__ack_rdy}); end
    total++; if ((bus.arb__mst__req_rdy | bus.arb__mst__ack_vld) !== '0) begin bad++; $display("FAIL rst_mst_hs got=%b/%b exp=0", bus.arb__mst__req_rdy, bus.arb__mst__ack_vld); end
    total++; if (bus.arb__mst__rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", bus.arb__mst__rd_data); end
    total++; if ({bus.arb__slv__addr, bus.arb__slv__wr_data} !== '0) begin bad++; $display("FAIL rst_payload got=%h/%h exp=0", bus.arb__slv__addr, bus.arb__slv__wr_data); end
    do_reset();
  endtask

  task automatic test_single;
    idle_inputs();
    step();
    addr_q[0] = 64'h100;
    data_q[0] = 32'hA5A5_A5A5;
    bus.mst__arb__addr[0 +: AW] = addr_q[0];
    bus.mst__arb__wr_data[0 +: DW] = data_q[0];
    bus.mst__arb__wr_en[0] = 1'b1;
    bus.mst__arb__req_vld = 4'b0001;
    bus.slv__arb__req_rdy = 1'b1;
    bus.slv__arb__ack_vld = 1'b1;
    bus.mst__arb__ack_rdy = 4'b0001;
    @(negedge clk);
    total++; if (bus.arb__slv__req_vld !== 1'b0) begin bad++; $display("FAIL single_idle_vld got=%b exp=0", bus.arb__slv__req_vld); end
    step();
    @(negedge clk);
    total++; if ({bus.arb__slv__req_vld, bus.arb__slv__wr_en, bus.arb__slv__rd_en} !== 3'b110) begin bad++; $display("FAIL single_req_ctrl got=%b exp=110", {bus.arb__slv__req_vld, bus.arb__slv__wr_en, bus.arb__slv__rd_en}); end
    total++; if ({bus.arb__slv__addr, bus.arb__slv__wr_data} !== {64'h100, 32'hA5A5_A5A5}) begin bad++; $display("FAIL single_payload got=%h/%h exp=100/a5a5a5a5", bus.arb__slv__addr, bus.arb__slv__wr_data); end
    total++; if ({bus.arb__grant, bus.arb__mst__req_rdy, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy} !== 13'b0001_0001_0000_0) begin
      bad++; $display("FAIL single_req_hs got=%b/%b/%b/%b exp=0001/0001/0000/0", bus.arb__grant, bus.arb__mst__req_rdy, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy); end
    step();
    bus.mst__arb__req_vld = '0;
    @(negedge clk);
    total++; if ({bus.arb__slv__req_vld, bus.arb__slv__wr_en, bus.arb__mst__req_rdy, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy} !== 11'b0_0_0000_0001_1) begin
      bad++; $display("FAIL single_ack got=%b/%b/%b/%b/%b exp=0/0/0000/0001/1", bus.arb__slv__req_vld, bus.arb__slv__wr_en, bus.arb__mst__req_rdy, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy); end
    step();
    @(negedge clk);
    total++; if ({bus.arb__grant, bus.arb__mst__ack_vld} !== 8'b0) begin bad++; $display("FAIL single_done got=%b/%b exp=0/0", bus.arb__grant, bus.arb__mst__ack_vld); end
    mptr = 1;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] ex;
    int w;
    do_reset();
    for (int i = 0; i < N; i++) load(i, 1'b1, 1'b0);
    bus.mst__arb__req_vld = '1;
    bus.slv__arb__req_rdy = 1'b1;
    bus.slv__arb__ack_vld = 1'b1;
    bus.mst__arb__ack_rdy = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (bus.arb__grant !== '0) begin bad++; $display("FAIL rr_idle_%0d got=%b exp=0", k, bus.arb__grant); end
      step();
      @(negedge clk);
      w = pick(mptr, '1);
      ex = N'(1) << w;
      total++; if (bus.arb__grant !== ex) begin bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, bus.arb__grant, ex); end
      total++; if (bus.arb__slv__addr !== addr_q[w]) begin bad++; $display("FAIL rr_addr_%0d got=%h exp=%h", k, bus.arb__slv__addr, addr_q[w]); end
      mptr = (w + 1) % N;
      step();
      step();
    end
    idle_inputs();
  endtask

  task automatic test_stall;
    logic [N-1:0] ex;
    int w;
    idle_inputs();
    step();
    load(2, 1'b0, 1'b1);
    bus.mst__arb__req_vld = 4'b0100;
    bus.slv__arb__ack_vld = 1'b1;
    bus.slv__arb__rd_data = 32'h1234_5678;
    w = pick(mptr, 4'b0100);
    ex = N'(1) << w;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if ({bus.arb__slv__req_vld, bus.arb__slv__rd_en, bus.arb__slv__addr} !== {2'b11, addr_q[w]}) begin
        bad++; $display("FAIL stall_payload_%0d got=%b%b/%h exp=11/%h", k, bus.arb__slv__req_vld, bus.arb__slv__rd_en, bus.arb__slv__addr, addr_q[w]); end
      total++; if ({bus.arb__mst__req_rdy, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy} !== 9'b0) begin
        bad++; $display("FAIL stall_hs_%0d got=%b/%b/%b exp=0", k, bus.arb__mst__req_rdy, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy); end
      step();
    end
    bus.slv__arb__req_rdy = 1'b1;
    @(negedge clk);
    total++; if (bus.arb__mst__req_rdy !== ex) begin bad++; $display("FAIL stall_req_rdy got=%b exp=%b", bus.arb__mst__req_rdy, ex); end
    step();
    bus.mst__arb__req_vld = '0;
    bus.slv__arb__req_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if ({bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy} !== {ex, 1'b0}) begin bad++; $display("FAIL stall_ack_hold_%0d got=%b/%b exp=%b/0", k, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy, ex); end
      step();
    end
    bus.mst__arb__ack_rdy = ex;
    @(negedge clk);
    total++; if ({bus.arb__slv__ack_rdy, bus.arb__mst__rd_data} !== {1'b1, 32'h1234_5678}) begin bad++; $display("FAIL stall_rd_data got=%b/%h exp=1/12345678", bus.arb__slv__ack_rdy, bus.arb__mst__rd_data); end
    step();
    @(negedge clk);
    total++; if ({bus.arb__grant, bus.arb__mst__rd_data} !== '0) begin bad++; $display("FAIL stall_done got=%b/%h exp=0/0", bus.arb__grant, bus.arb__mst__rd_data); end
    mptr = (w + 1) % N;
    idle_inputs();
  endtask

  task automatic test_abort_owner;
    logic [N-1:0] ex;
    int w;
    step();
    load(1, 1'b1, 1'b0);
    load(2, 1'b1, 1'b0);
    bus.mst__arb__req_vld = 4'b0110;
    bus.slv__arb__req_rdy = 1'b1;
    bus.mst__arb__ack_rdy = '1;
    w = pick(mptr, 4'b0110);
    ex = N'(1) << w;
    step();
    @(negedge clk);
    total++; if (bus.arb__grant !== ex) begin bad++; $display("FAIL abort_grant got=%b exp=%b", bus.arb__grant, ex); end
    step();
    bus.mst__arb__req_vld = 4'b0110 & ~ex;
    bus.mst__arb__sync_reset = ex;
    @(negedge clk);
    total++; if (bus.arb__mst__ack_vld !== '0) begin bad++; $display("FAIL abort_no_ack got=%b exp=0", bus.arb__mst__ack_vld); end
    step();
    bus.mst__arb__sync_reset = '0;
    mptr = (w + 1) % N;
    @(negedge clk);
    total++; if ({bus.arb__slv__sync_reset, bus.arb__slv__req_vld, bus.arb__grant} !== {2'b10, 4'b0}) begin
      bad++; $display("FAIL abort_pulse got=%b/%b/%b exp=1/0/0000", bus.arb__slv__sync_reset, bus.arb__slv__req_vld, bus.arb__grant); end
    step();
    w = pick(mptr, bus.mst__arb__req_vld);
    ex = N'(1) << w;
    @(negedge clk);
    total++; if ({bus.arb__slv__sync_reset, bus.arb__grant} !== {1'b0, ex}) begin bad++; $display("FAIL abort_next got=%b/%b exp=0/%b", bus.arb__slv__sync_reset, bus.arb__grant, ex); end
    total++; if (bus.arb__slv__addr !== addr_q[w]) begin bad++; $display("FAIL abort_next_addr got=%h exp=%h", bus.arb__slv__addr, addr_q[w]); end
    step();
    bus.mst__arb__req_vld = '0;
    bus.slv__arb__ack_vld = 1'b1;
    step();
    mptr = (w + 1) % N;
    idle_inputs();
  endtask

  task automatic test_nonowner_abort;
    logic [N-1:0] ex;
    int w;
    step();
    load(0, 1'b1, 1'b0);
    bus.mst__arb__req_vld = 4'b0001;
    bus.slv__arb__req_rdy = 1'b1;
    bus.slv__arb__ack_vld = 1'b1;
    bus.mst__arb__ack_rdy = 4'b0001;
    w = pick(mptr, 4'b0001);
    ex = N'(1) << w;
    step();
    bus.mst__arb__sync_reset = 4'b1000;
    @(negedge clk);
    total++; if (bus.arb__mst__req_rdy !== ex) begin bad++; $display("FAIL nonowner_req_rdy got=%b exp=%b", bus.arb__mst__req_rdy, ex); end
    step();
    bus.mst__arb__req_vld = '0;
    bus.mst__arb__sync_reset = 4'b1000 | ex;
    @(negedge clk);
    total++; if ({bus.arb__mst__ack_vld, bus.arb__slv__sync_reset} !== {ex, 1'b0}) begin bad++; $display("FAIL nonowner_ack got=%b/%b exp=%b/0", bus.arb__mst__ack_vld, bus.arb__slv__sync_reset, ex); end
    step();
    bus.mst__arb__sync_reset = '0;
    @(negedge clk);
    total++; if ({bus.arb__slv__sync_reset, bus.arb__grant} !== 5'b0) begin bad++; $display("FAIL ack_beats_abort got=%b/%b exp=0/0000", bus.arb__slv__sync_reset, bus.arb__grant); end
    mptr = (w + 1) % N;
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] ex;
    int w;
    step();
    load(2, 1'b0, 1'b1);
    bus.mst__arb__req_vld = 4'b0100;
    bus.slv__arb__req_rdy = 1'b1;
    bus.slv__arb__ack_vld = 1'b1;
    bus.slv__arb__rd_data = $urandom;
    w = pick(mptr, 4'b0100);
    ex = N'(1) << w;
    step();
    bus.mst__arb__req_vld = '0;
    step();
    @(negedge clk);
    total++; if (bus.arb__mst__ack_vld !== ex) begin bad++; $display("FAIL midrst_pending got=%b exp=%b", bus.arb__mst__ack_vld, ex); end
    #1 rstn = 1'b0;
    #1;
    total++; if ({bus.arb__grant, bus.arb__mst__ack_vld, bus.arb__mst__req_rdy, bus.arb__slv__ack_rdy, bus.arb__slv__req_vld, bus.arb__slv__rd_en} !== '0) begin
      bad++; $display("FAIL midrst_ctrl got=%b/%b/%b/%b/%b/%b exp=0", bus.arb__grant, bus.arb__mst__ack_vld, bus.arb__mst__req_rdy, bus.arb__slv__ack_rdy, bus.arb__slv__req_vld, bus.arb__slv__rd_en); end
    total++; if ({bus.arb__mst__rd_data, bus.arb__slv__addr} !== '0) begin bad++; $display("FAIL midrst_data got=%h/%h exp=0", bus.arb__mst__rd_data, bus.arb__slv__addr); end
    step();
    rstn = 1'b1;
    mptr = 0;
    for (int i = 0; i < N; i++) load(i, 1'b1, 1'b0);
    bus.mst__arb__req_vld = '1;
    bus.mst__arb__ack_rdy = '1;
    step();
    w = pick(mptr, '1);
    ex = N'(1) << w;
    @(negedge clk);
    total++; if (bus.arb__grant !== ex) begin bad++; $display("FAIL midrst_first_grant got=%b exp=%b", bus.arb__grant, ex); end
    step();
    bus.mst__arb__req_vld = '0;
    step();
    mptr = (w + 1) % N;
    idle_inputs();
  endtask

  task automatic test_random;
    logic [N-1:0] m, ex;
    logic [DW-1:0] rd;
    int w, d, e;
    bit ab;
    for (int t = 0; t < 40; t++) begin
      idle_inputs();
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) load(i, 1'($urandom), 1'($urandom));
      bus.mst__arb__req_vld = m;
      rd = $urandom;
      bus.slv__arb__rd_data = rd;
      w = pick(mptr, m);
      ex = N'(1) << w;
      d = $urandom_range(0, 3);
      e = $urandom_range(0, 3);
      ab = ($urandom_range(0, 5) == 0);
      step();
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        total++; if ({bus.arb__grant, bus.arb__slv__addr} !== {ex, addr_q[w]}) begin bad++; $display("FAIL rnd_req_%0d got=%b/%h exp=%b/%h", t, bus.arb__grant, bus.arb__slv__addr, ex, addr_q[w]); end
        step();
      end
      bus.slv__arb__req_rdy = 1'b1;
      @(negedge clk);
      total++; if ({bus.arb__mst__req_rdy, bus.arb__slv__wr_data, bus.arb__slv__wr_en, bus.arb__slv__rd_en} !== {ex, data_q[w], bus.mst__arb__wr_en[w], bus.mst__arb__rd_en[w]}) begin
        bad++; $display("FAIL rnd_accept_%0d got=%b/%h/%b%b exp=%b/%h", t, bus.arb__mst__req_rdy, bus.arb__slv__wr_data, bus.arb__slv__wr_en, bus.arb__slv__rd_en, ex, data_q[w]); end
      step();
      bus.mst__arb__req_vld = '0;
      bus.slv__arb__req_rdy = 1'b0;
      bus.slv__arb__ack_vld = 1'b1;
      bus.mst__arb__ack_rdy = N'($urandom) & ~ex;
      for (int k = 0; k < e; k++) begin
        @(negedge clk);
        total++; if ({bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy} !== {ex, 1'b0}) begin bad++; $display("FAIL rnd_ack_wait_%0d got=%b/%b exp=%b/0", t, bus.arb__mst__ack_vld, bus.arb__slv__ack_rdy, ex); end
        step();
      end
      if (ab) bus.mst__arb__sync_reset = ex;
      else bus.mst__arb__ack_rdy = bus.mst__arb__ack_rdy | ex;
      @(negedge clk);
      total++; if ({bus.arb__slv__ack_rdy, bus.arb__mst__rd_data} !== {!ab, rd}) begin bad++; $display("FAIL rnd_ack_%0d got=%b/%h exp=%b/%h", t, bus.arb__slv__ack_rdy, bus.arb__mst__rd_data, !ab, rd); end
      step();
      bus.mst__arb__sync_reset = '0;
      bus.slv__arb__ack_vld = 1'b0;
      @(negedge clk);
      total++; if ({bus.arb__slv__sync_reset, bus.arb__grant} !== {ab, {N{1'b0}}}) begin bad++; $display("FAIL rnd_end_%0d got=%b/%b exp=%b/0", t, bus.arb__slv__sync_reset, bus.arb__grant, ab); end
      mptr = (w + 1) % N;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_abort_owner();
    test_nonowner_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
